// File: rtl/echo_capture_store.sv
// Capture store for the receiver write stream, with 16-bit valid/ready readout to the host.
// Optional trailing XOR checksum beat is enabled by defining CAPTURE_CHECKSUM_EN.
module echo_capture_store #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 499
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] WR_ADDR,
    input  logic [31:0] WR_DATA,
    input  logic        WR_TR,
    input  logic        WR_OVER,
    input  logic        CLEAR,
    input  logic        RD_START,
    input  logic        RD_READY,
    output logic [15:0] RD_DATA,
    output logic        RD_VALID,
    output logic        RD_BUSY,
    output logic        DONE,
    output logic        HDR_SEEN,
    output logic        ERR_RANGE,
    output logic [15:0] SAMPLE_COUNT
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

`ifdef CAPTURE_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_CAPT, S_FROZEN, S_RD_ISSUE, S_RD_HI, S_RD_LO, S_RD_CSUM
    } state_t;
`else
    typedef enum logic [2:0] {
        S_CAPT, S_FROZEN, S_RD_ISSUE, S_RD_HI, S_RD_LO
    } state_t;
`endif

    state_t              r_state;
    state_t              w_next;
    logic                r_wr_tr_q;
    logic                r_wr_over_q;
    logic                r_done;
    logic                r_hdr_seen;
    logic                r_err_range;
    logic [15:0]         r_count;
    logic [ADDR_W-1:0]   r_idx;
    logic [31:0]         r_rd_word;
    logic [31:0]         r_mem [DEPTH];

    logic                w_wr_ev;
    logic                w_over_ev;
    logic [16:0]         w_off;
    logic                w_in_range;
    logic                w_accept;
    logic [ADDR_W-1:0]   w_last_idx;
    logic                w_idx_inc;
    logic                w_start;
    logic                w_clear;
    logic [15:0]         w_rd_data;
    logic                w_rd_valid;
    logic                w_rd_busy;

`ifdef CAPTURE_CHECKSUM_EN
    logic [15:0]         r_csum;
`endif

    assign w_wr_ev    = WR_TR & ~r_wr_tr_q;
    assign w_over_ev  = WR_OVER & ~r_wr_over_q;
    // Negative offsets wrap to values >= 2^16, so one unsigned compare covers both bounds.
    assign w_off      = {1'b0, WR_ADDR} - 17'(BASE_ADDR);
    assign w_in_range = (w_off < 17'(DEPTH));
    assign w_accept   = w_wr_ev && (r_state == S_CAPT);
    assign w_last_idx = (r_count > 16'(DEPTH - 1)) ? '1 : r_count[ADDR_W-1:0];
    assign w_clear    = (r_state == S_FROZEN) && CLEAR;
    assign w_start    = (r_state == S_FROZEN) && !CLEAR && RD_START;

    always_ff @(posedge CLK) begin
        if (w_accept && w_in_range) begin
            r_mem[w_off[ADDR_W-1:0]] <= WR_DATA;
        end
        r_rd_word <= r_mem[r_idx];
    end

    always_comb begin
        w_next     = r_state;
        w_rd_data  = '0;
        w_rd_valid = 1'b0;
        w_rd_busy  = 1'b0;
        w_idx_inc  = 1'b0;
        case (r_state)
            S_CAPT: begin
                if (w_over_ev) w_next = S_FROZEN;
            end
            S_FROZEN: begin
                if (CLEAR)         w_next = S_CAPT;
                else if (RD_START) w_next = S_RD_ISSUE;
            end
            S_RD_ISSUE: begin
                w_rd_busy = 1'b1;
                w_next    = S_RD_HI;
            end
            S_RD_HI: begin
                w_rd_busy  = 1'b1;
                w_rd_valid = 1'b1;
                w_rd_data  = r_rd_word[31:16];
                if (RD_READY) w_next = S_RD_LO;
            end
            S_RD_LO: begin
                w_rd_busy  = 1'b1;
                w_rd_valid = 1'b1;
                w_rd_data  = r_rd_word[15:0];
                if (RD_READY) begin
                    if (r_idx == w_last_idx) begin
`ifdef CAPTURE_CHECKSUM_EN
                        w_next = S_RD_CSUM;
`else
                        w_next = S_FROZEN;
`endif
                    end else begin
                        w_idx_inc = 1'b1;
                        w_next    = S_RD_ISSUE;
                    end
                end
            end
`ifdef CAPTURE_CHECKSUM_EN
            S_RD_CSUM: begin
                w_rd_busy  = 1'b1;
                w_rd_valid = 1'b1;
                w_rd_data  = r_csum;
                if (RD_READY) w_next = S_FROZEN;
            end
`endif
            default: w_next = S_CAPT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_CAPT;
            r_wr_tr_q   <= 1'b0;
            r_wr_over_q <= 1'b0;
            r_done      <= 1'b0;
            r_hdr_seen  <= 1'b0;
            r_err_range <= 1'b0;
            r_count     <= '0;
            r_idx       <= '0;
        end else begin
            r_state     <= w_next;
            r_wr_tr_q   <= WR_TR;
            r_wr_over_q <= WR_OVER;
            if (w_accept) begin
                if (!w_in_range) begin
                    r_err_range <= 1'b1;
                end else if (w_off == '0) begin
                    r_hdr_seen <= 1'b1;
                end else if (r_count != '1) begin
                    r_count <= r_count + 16'd1;
                end
            end
            if ((r_state == S_CAPT) && w_over_ev) r_done <= 1'b1;
            if (w_clear) begin
                r_done      <= 1'b0;
                r_hdr_seen  <= 1'b0;
                r_err_range <= 1'b0;
                r_count     <= '0;
            end
            if (w_start)        r_idx <= '0;
            else if (w_idx_inc) r_idx <= r_idx + 1'b1;
        end
    end

`ifdef CAPTURE_CHECKSUM_EN
    always_ff @(posedge CLK) begin
        if (RESET || w_start) begin
            r_csum <= '0;
        end else if (RD_READY && ((r_state == S_RD_HI) || (r_state == S_RD_LO))) begin
            r_csum <= r_csum ^ w_rd_data;
        end
    end
`endif

    assign RD_DATA      = w_rd_data;
    assign RD_VALID     = w_rd_valid;
    assign RD_BUSY      = w_rd_busy;
    assign DONE         = r_done;
    assign HDR_SEEN     = r_hdr_seen;
    assign ERR_RANGE    = r_err_range;
    assign SAMPLE_COUNT = r_count;

endmodule
